// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline constants: register-file geometry, result latencies and the
// SPECIAL-opcode funct codes that decode uses to raise id_is_muldiv / id_reads_hilo.
package pipeline_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;
  localparam int HILO_W   = 6;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam int LAT_ALU           = 0;
  localparam int LAT_LOAD          = 1;
  localparam int MULDIV_CYCLES_DEF = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  typedef enum logic [5:0] {
    FN_MFHI  = 6'h10,
    FN_MFLO  = 6'h12,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B
  } funct_e;

  function automatic logic is_muldiv_op(input logic [5:0] opcode, input logic [5:0] funct);
    logic hit;
    case (funct)
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return (opcode == OP_SPECIAL) && hit;
  endfunction

  function automatic logic is_hilo_read_op(input logic [5:0] opcode, input logic [5:0] funct);
    logic hit;
    case (funct)
      FN_MFHI, FN_MFLO: hit = 1'b1;
      default:          hit = 1'b0;
    endcase
    return (opcode == OP_SPECIAL) && hit;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage issue interface: decoded operand/destination info and redirect go in,
// issue/stall/flush decisions come back.
interface pipeline_hazard_ctrl_if #(parameter int LAT_W = 2);
  import pipeline_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;
  logic [LAT_W-1:0] id_dest_lat;
  logic             id_is_muldiv;
  logic             id_reads_hilo;
  logic             redirect;

  logic issue;
  logic stall_if;
  logic stall_id;
  logic bubble_ex;
  logic flush_id;
  logic hilo_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_dest_lat,
           id_is_muldiv, id_reads_hilo, redirect,
    input  issue, stall_if, stall_id, bubble_ex, flush_id, hilo_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_dest_lat,
           id_is_muldiv, id_reads_hilo, redirect,
    output issue, stall_if, stall_id, bubble_ex, flush_id, hilo_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_reg_scoreboard.sv
// Per-register pending-latency counters (r1..r31). Every edge all counters count
// down; a load never shortens an entry's outstanding window (WAW-safe max).
module reg_scoreboard
  import pipeline_pkg::*;
#(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_en,
  input  logic             load_en,
  input  logic [REG_W-1:0] load_idx,
  input  logic [LAT_W-1:0] load_lat,
  input  logic [REG_W-1:0] rd_idx_a,
  input  logic [REG_W-1:0] rd_idx_b,
  output logic             pend_a,
  output logic             pend_b
);

  logic [LAT_W-1:0]    cnt_r   [1:NUM_REGS-1];
  logic [LAT_W-1:0]    dec_s   [1:NUM_REGS-1];
  logic [LAT_W-1:0]    nxt_s   [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] pend_vec_s;

  // Next-count: saturating decrement, then max-merge with a load to this entry.
  always_comb begin
    pend_vec_s = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (dec_en && (cnt_r[i] != {LAT_W{1'b0}})) begin
        dec_s[i] = cnt_r[i] - {{(LAT_W-1){1'b0}}, 1'b1};
      end else begin
        dec_s[i] = cnt_r[i];
      end
      if (load_en && (load_idx == REG_W'(i)) && (load_lat > dec_s[i])) begin
        nxt_s[i] = load_lat;
      end else begin
        nxt_s[i] = dec_s[i];
      end
      pend_vec_s[i] = (cnt_r[i] != {LAT_W{1'b0}});
    end
  end

  // Counter bank state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        cnt_r[i] <= {LAT_W{1'b0}};
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        cnt_r[i] <= nxt_s[i];
      end
    end
  end

  // Bit 0 of pend_vec_s is constant zero, so r0 never reports pending.
  assign pend_a = pend_vec_s[rd_idx_a];
  assign pend_b = pend_vec_s[rd_idx_b];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage issue controller: combines register scoreboard and HI/LO busy counter
// into issue / stall / bubble / flush decisions. Redirect overrides stall.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int LAT_W         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [HILO_W-1:0] MULDIV_LOAD = HILO_W'(MULDIV_CYCLES);

  logic [HILO_W-1:0] hilo_cnt_r;
  logic              pend_rs_s;
  logic              pend_rt_s;
  logic              hilo_pend_s;
  logic              hazard_s;
  logic              issue_s;
  logic              stall_s;
  logic              load_en_s;

  reg_scoreboard #(.LAT_W(LAT_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .dec_en   (1'b1),
    .load_en  (load_en_s),
    .load_idx (bus.id_dest),
    .load_lat (bus.id_dest_lat),
    .rd_idx_a (bus.id_rs),
    .rd_idx_b (bus.id_rt),
    .pend_a   (pend_rs_s),
    .pend_b   (pend_rt_s)
  );

  // Hazard detection and issue/stall/flush decode.
  always_comb begin
    hilo_pend_s = (hilo_cnt_r != {HILO_W{1'b0}});
    hazard_s    = (bus.id_uses_rs & pend_rs_s)
                | (bus.id_uses_rt & pend_rt_s)
                | ((bus.id_reads_hilo | bus.id_is_muldiv) & hilo_pend_s);
    if (bus.redirect) begin
      issue_s = 1'b0;
      stall_s = 1'b0;
    end else begin
      issue_s = bus.id_valid & ~hazard_s;
      stall_s = bus.id_valid &  hazard_s;
    end
    load_en_s = issue_s & (bus.id_dest != REG_ZERO) & (bus.id_dest_lat != {LAT_W{1'b0}});

    bus.issue     = issue_s;
    bus.stall_if  = stall_s;
    bus.stall_id  = stall_s;
    bus.bubble_ex = stall_s;
    bus.flush_id  = bus.redirect;
    bus.hilo_busy = hilo_pend_s;
  end

  // HI/LO unit busy counter; a new mult/div can only issue once it reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_cnt_r <= {HILO_W{1'b0}};
    end else if (issue_s && bus.id_is_muldiv) begin
      hilo_cnt_r <= MULDIV_LOAD;
    end else if (hilo_cnt_r != {HILO_W{1'b0}}) begin
      hilo_cnt_r <= hilo_cnt_r - {{(HILO_W-1){1'b0}}, 1'b1};
    end else begin
      hilo_cnt_r <= hilo_cnt_r;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Issue controller for the 5-stage pipeline. It sits beside the instruction-decode stage and decides each cycle whether the decoded instruction issues to EX, stalls in ID, or is flushed. It keeps a per-register scoreboard of pending result latencies and a busy counter for the multi-cycle HI/LO (mult/div) unit. It also applies branch/jump redirects from EX.

Parameters:
MULDIV_CYCLES, 32, cycles the mult/div unit stays busy after a MULT/MULTU/DIV/DIVU issues (legal range 1..63).
LAT_W, 2, width of the per-register pending-latency counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  5  source register A
id_rt  input  5  source register B
id_uses_rs  input  1  instruction reads rs
id_uses_rt  input  1  instruction reads rt
id_dest  input  5  destination register
id_dest_lat  input  LAT_W  cycles after issue until the result is forwardable; 0 = ALU result, forwarded immediately
id_is_muldiv  input  1  instruction starts a mult/div
id_reads_hilo  input  1  MFHI/MFLO
redirect  input  1  EX resolved a taken branch/jump this cycle
issue  output  1  ID instruction advances to EX this cycle
stall_if  output  1  hold PC and the IF/ID register
stall_id  output  1  hold the ID/EX input register contents
bubble_ex  output  1  insert a NOP into EX
flush_id  output  1  clear the IF/ID register (wrong-path instruction)
hilo_busy  output  1  mult/div counter nonzero

Behaviour:
- State: cnt[1..31] (LAT_W bits each) and hilo_cnt (6 bits). There is no cnt[0]; register 0 never creates a hazard.
- hazard = (id_uses_rs & id_rs!=0 & cnt[id_rs]!=0) | (id_uses_rt & id_rt!=0 & cnt[id_rt]!=0) | ((id_reads_hilo | id_is_muldiv) & hilo_cnt!=0).
- Outputs are combinational from state and inputs:
  - issue = id_valid & ~hazard & ~redirect
  - stall_if = stall_id = bubble_ex = id_valid & hazard & ~redirect
  - flush_id = redirect
  - hilo_busy = (hilo_cnt != 0)
- Redirect has priority over stall. With redirect=1 the ID instruction is discarded, not stalled, and does not update the scoreboard.
- Every clock edge with rst=0:
  - Each nonzero cnt decrements by 1, and hilo_cnt decrements if nonzero.
  - Then, if issue & id_dest!=0 & id_dest_lat!=0: cnt[id_dest] <= max(id_dest_lat, cnt[id_dest]-1), saturating at 0. This covers WAW: the later writer never shortens the pending window.
  - If issue & id_is_muldiv: hilo_cnt <= MULDIV_CYCLES.
- Decrement and load of the same entry in one cycle: the load value per the max rule wins.
- Latency: a consumer issued after a producer with lat L stalls exactly L cycles if it is back-to-back with the producer.
- Reset (asynchronous, any time, including mid-mult/div):
  - All cnt and hilo_cnt clear immediately.
  - With id_valid=0 and redirect=0: issue=0, stall_if=0, stall_id=0, bubble_ex=0, flush_id=0, hilo_busy=0.
  - Following reset, outputs follow the inputs combinationally over zero state.
- id_valid=0: issue=0, no stall, scoreboard only decrements.
- A hazard check uses pre-edge state. A producer issued in cycle N is visible to the ID instruction at cycle N+1.

Decomposition:
- Shared package pipeline_pkg: REG_ZERO, latency constants LAT_ALU=0, LAT_LOAD=1, MULDIV_CYCLES default, and the opcode/funct constants for MULT/MULTU/DIV/DIVU/MFHI/MFLO used by the decode-side generation of id_is_muldiv/id_reads_hilo.
- One sub-module, reg_scoreboard: the 31-entry counter bank. It has a decrement-all, a load port and two read ports returning "pending" bits. pipeline_hazard_ctrl adds the HI/LO counter and the issue/stall/flush logic.

Test Plan:
- Load-use: issue lw with dest=8, lat=1; next cycle add with rs=8 -> issue=0, stall_if=stall_id=bubble_ex=1 for 1 cycle, then issue=1.
- Register zero: issue with dest=0, lat=1, then consumer with rs=0 -> no stall, issue=1 both cycles.
- Mult/div: issue DIV with MULDIV_CYCLES=32, then MFLO held in ID -> stalls exactly 32 cycles, hilo_busy=1 throughout, issue=1 on cycle 33; a second DIV issued during busy also stalls.
- Redirect during stall: load-use stall pending with redirect=1 -> flush_id=1, issue=0, stall_if=0, and cnt of the flushed instruction's dest is unchanged.
- WAW max: cnt[9]=2 (LAT_W=2, dest lat 3 then lat 1 next cycle) -> after second issue cnt[9]=2, not 1; a consumer of reg 9 stalls 2 cycles.
- Reset mid-operation: assert rst 10 cycles into a DIV with MFLO waiting -> hilo_busy=0 and stall_if=0 immediately (asynchronous); after release, MFLO issues on the first cycle.
